uart_rx_sampler: RTL and testbench

- Serial receiver that feeds the UART memory-mapped peripheral's Rx path; sits between the board rx pin and the register bank that exposes Rx data (offset 0x10), the data-received flag (0x14) and the Rx clear register (0x18).
- Synchronises the asynchronous rx line, oversamples it, frames 8N1 characters and presents the byte with a sticky received flag until software clears it.
- Also reports framing and overrun errors for later status-register use.

---
 rtl/uart_rx_sampler.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// Oversampling 8N1 UART receiver with sticky received/framing/overrun flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames and expose parity_err.
module uart_rx_sampler #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rx_flag_clr,
    output logic [7:0] rx_data,
    output logic       rx_flag,
    output logic       frame_err,
    output logic       overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W  = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [TICK_W-1:0] MID_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] BIT_LAST = TICK_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } state_t;

    state_t              state;
    logic                rx_meta;
    logic                rx_s;
    logic                rx_prev;
    logic [DIV_W-1:0]    div_cnt;
    logic [TICK_W-1:0]   tick_cnt;
    logic [2:0]          bit_idx;
    logic [7:0]          shreg;
    logic                tick;
`ifdef UART_RX_PARITY_EN
    logic                par_bit;
`endif

    // Synchroniser presets to the idle level so reset release never fakes a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Baud-tick divider is held at zero while idle so the first tick aligns to the start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (state == IDLE || div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (state != IDLE) && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_flag   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            // Clear first; a completing frame below overrides it in the same cycle.
            if (rx_flag_clr) begin
                rx_flag   <= 1'b0;
                frame_err <= 1'b0;
                overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err <= 1'b0;
`endif
            end

            case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                end

                START: begin
                    if (tick) begin
                        if (tick_cnt == MID_LAST) begin
                            tick_cnt <= '0;
                            bit_idx  <= '0;
                            state    <= rx_s ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            shreg    <= {rx_s, shreg[7:1]};
                            bit_idx  <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            par_bit  <= rx_s;
                            state    <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
`endif

                STOP: begin
                    if (tick) begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            if (rx_s) begin
                                rx_data   <= shreg;
                                rx_flag   <= 1'b1;
                                frame_err <= 1'b0;
                                if (rx_flag) begin
                                    overrun <= 1'b1;
                                end
`ifdef UART_RX_PARITY_EN
                                parity_err <= (^shreg) ^ par_bit;
`endif
                                state <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= BREAK_WAIT;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                BREAK_WAIT: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: stimulus pushes expected frame outcomes,
// a negedge monitor pops and compares whenever the outputs report a new event.
module tb_uart_rx_sampler;

    localparam int CLK_FREQ   = 1600000;
    localparam int BAUD_RATE  = 100000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS   = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    // Line-to-flag latency: 9.5 bit times plus synchroniser/edge detect, plus one parity bit.
    localparam int LAT = (19 * BIT_CLKS) / 2 + 3 + (PAR ? BIT_CLKS : 0);

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       rx_flag_clr;
    logic [7:0] rx_data;
    logic       rx_flag;
    logic       frame_err;
    logic       overrun;
    logic       perr_obs;

    uart_rx_sampler #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .rx_flag_clr (rx_flag_clr),
        .rx_data     (rx_data),
        .rx_flag     (rx_flag),
        .frame_err   (frame_err),
        .overrun     (overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err  (perr_obs)
`endif
    );
`ifndef UART_RX_PARITY_EN
    assign perr_obs = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       flag;
        logic       ferr;
        logic       ovr;
        logic       perr;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Reference model state: what software would see in the status registers.
    logic [7:0] m_data = 8'h00;
    logic       m_flag = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_ovr  = 1'b0;
    logic       m_perr = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_bit(input logic v);
        rx = v;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_flag = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        m_perr = 1'b0;
    endtask

    task automatic pulse_clr();
        rx_flag_clr = 1'b1;
        @(posedge clk);
        #1;
        rx_flag_clr = 1'b0;
        model_clear();
        check("clr_flag", rx_flag, 1'b0);
        check("clr_frame_err", frame_err, 1'b0);
        check("clr_overrun", overrun, 1'b0);
    endtask

    // Sends one frame starting now; records the outcome the status registers should show.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic pbit,
                              input logic clr_held);
        exp_t e;
        if (stop_ok) begin
            m_ovr  = clr_held ? 1'b0 : (m_ovr | m_flag);
            m_flag = 1'b1;
            m_data = b;
            m_ferr = 1'b0;
            m_perr = PAR ? ((^b) ^ pbit) : 1'b0;
        end else begin
            m_ferr = 1'b1;
        end
        e.data = m_data; e.flag = m_flag; e.ferr = m_ferr;
        e.ovr  = m_ovr;  e.perr = m_perr; e.cyc  = cyc + LAT;
        sb.push_back(e);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        if (PAR) hold_bit(pbit);
        rx = stop_ok;
        for (int i = 0; i < BIT_CLKS; i++) begin
            @(posedge clk);
            #1;
            if (clr_held && cyc == e.cyc) check("held_clr_flag_on", rx_flag, 1'b1);
            if (clr_held && cyc == e.cyc + 1) check("held_clr_flag_off", rx_flag, 1'b0);
        end
        rx = 1'b1;
        if (clr_held) model_clear();
    endtask

    task automatic false_start(input int low_clks);
        rx = 1'b0;
        repeat (low_clks) @(posedge clk);
        #1;
        idle(24);
        check("false_start_flag", rx_flag, m_flag);
        check("false_start_data", rx_data, m_data);
        check("false_start_ferr", frame_err, m_ferr);
    endtask

    // Monitor: a new event is a rising flag/error or a new byte while the flag is still up.
    logic [7:0] p_data = 8'h00;
    logic       p_flag = 1'b0;
    logic       p_ferr = 1'b0;
    logic       p_ovr  = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        logic ev;
        ev = rst_n && ((rx_flag && !p_flag) || (frame_err && !p_ferr) || (overrun && !p_ovr) ||
                       (rx_flag && p_flag && rx_data != p_data));
        if (ev) begin
            if (sb.size() == 0) begin
                check("unexpected_event", 1, 0);
            end else begin
                e = sb.pop_front();
                check("ev_cycle", cyc, e.cyc);
                check("ev_data", rx_data, e.data);
                check("ev_flag", rx_flag, e.flag);
                check("ev_frame_err", frame_err, e.ferr);
                check("ev_overrun", overrun, e.ovr);
`ifdef UART_RX_PARITY_EN
                check("ev_parity_err", perr_obs, e.perr);
`endif
            end
        end
        p_data = rx_data;
        p_flag = rx_flag;
        p_ferr = frame_err;
        p_ovr  = overrun;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] b2;
        int         mode;

        rst_n = 1'b0;
        rx = 1'b1;
        rx_flag_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", rx_data, 8'h00);
        check("reset_flag", rx_flag, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        rst_n = 1'b1;
        idle(8);

        // Basic byte and its exact latency (checked by the monitor's cycle compare).
        send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0);
        idle(10);
        check("a5_data", rx_data, 8'hA5);
        check("a5_flag", rx_flag, 1'b1);

        false_start(6);

        pulse_clr();
        idle(4);
        send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0);
        idle(10);
        check("bad_stop_flag", rx_flag, 1'b0);
        check("bad_stop_data", rx_data, 8'hA5);
        check("bad_stop_ferr", frame_err, 1'b1);
        send_frame(8'h55, 1'b1, ^8'h55, 1'b0);
        idle(10);

        pulse_clr();
        idle(4);
        send_frame(8'h11, 1'b1, ^8'h11, 1'b0);
        send_frame(8'h22, 1'b1, ^8'h22, 1'b0);
        idle(10);
        check("overrun_data", rx_data, 8'h22);
        check("overrun_flag", overrun, 1'b1);
        pulse_clr();
        idle(4);

        rx_flag_clr = 1'b1;
        idle(4);
        send_frame(8'h7E, 1'b1, ^8'h7E, 1'b1);
        idle(4);
        rx_flag_clr = 1'b0;
        check("held_clr_data", rx_data, 8'h7E);
        idle(4);
        send_frame(8'h99, 1'b1, ^8'h99, 1'b0);
        idle(6);

        // Abandon a frame with reset partway through the data bits.
        hold_bit(1'b0);
        hold_bit(1'b1);
        hold_bit(1'b0);
        hold_bit(1'b1);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midreset_data", rx_data, 8'h00);
        check("midreset_flag", rx_flag, 1'b0);
        check("midreset_ferr", frame_err, 1'b0);
        check("midreset_ovr", overrun, 1'b0);
        m_data = 8'h00;
        model_clear();
        rst_n = 1'b1;
        idle(40);
        send_frame(8'hC3, 1'b1, ^8'hC3, 1'b0);
        idle(10);

`ifdef UART_RX_PARITY_EN
        pulse_clr();
        idle(4);
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        idle(10);
        check("par_bad", perr_obs, 1'b1);
        pulse_clr();
        idle(4);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        idle(10);
        check("par_good", perr_obs, 1'b0);
`endif

        for (int it = 0; it < 12; it++) begin
            mode = $urandom_range(0, 3);
            b = 8'($urandom);
            b2 = b ^ 8'h5A;
            case (mode)
                0: begin
                    pulse_clr(); idle(4);
                    send_frame(b, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
                end
                1: begin
                    pulse_clr(); idle(4);
                    send_frame(b, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
                end
                2: false_start($urandom_range(1, 6));
                default: begin
                    pulse_clr(); idle(4);
                    send_frame(b, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
                    send_frame(b2, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
                end
            endcase
            idle(12);
            check("rand_data", rx_data, m_data);
            check("rand_flag", rx_flag, m_flag);
        end

        idle(20);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
